remote_comm: RTL and testbench
==============================

# remote_comm

Host-side command initiator for the Bluetooth command link. Accepts a 16-bit command from the test/host logic and serializes it over the existing UART as two bytes, high byte first. It then waits for the one-byte response from the far-end command receiver and reports whether that response is the positive acknowledge. Sits between host stimulus logic and the serial line, as the counterpart of the robot-side UART command receiver.

## Interface
- `RESP_ACK`, default 8'hA5: response byte treated as positive acknowledge.
- `TIMEOUT_CYCLES`, default 24'd10_000_000: clk cycles allowed in WAIT_RESP before timeout. Used only when timeout is compiled in.
- `clk` input, 1: system clock; all state on the rising edge.
- `rst` input, 1: asynchronous, active-high reset. The internal UART receives ~rst as its rst_n.
- `snd_cmd` input, 1: one-cycle request to send `cmd`; honoured only in IDLE.
- `cmd` input, 16: command word; captured on the accepted `snd_cmd` cycle.
- `RX` input, 1: serial in from the far end.
- `TX` output, 1: serial out to the far end. Idles at 1.
- `busy` output, 1: high in every state except IDLE.
- `cmd_snt` output, 1: one-cycle pulse when the low byte's `tx_done` is seen.
- `resp_rdy` output, 1: one-cycle pulse when a response byte is captured.
- `resp` output, 8: last response byte; held until the next capture.
- `ack` output, 1: registered `resp == RESP_ACK`, updated with `resp`.
- `timeout` output, 1: one-cycle pulse on response timeout. Only exists as logic when compiled in; otherwise tied 0.

## Operation
- Instantiates UART internally. trmt, tx_data and clr_rx_rdy are driven from registered FSM outputs.
- `cmd` is captured into a 16-bit shadow register, so the host may change `cmd` after acceptance.
- FSM states: IDLE, SND_HI, WAIT_HI, SND_LO, WAIT_LO, WAIT_RESP.
- IDLE -> SND_HI on `snd_cmd`; the shadow register loads.
- SND_HI: trmt=1 for exactly one cycle, tx_data=shadow[15:8], then -> WAIT_HI.
- WAIT_HI -> SND_LO on tx_done=1.
- SND_LO: trmt=1 for one cycle, tx_data=shadow[7:0], then -> WAIT_LO.
- WAIT_LO -> WAIT_RESP on tx_done=1; pulse `cmd_snt`.
- WAIT_RESP -> IDLE on rx_rdy=1. On that transition: latch rx_data into `resp`, update `ack`, pulse `resp_rdy`, pulse clr_rx_rdy.
- `snd_cmd` outside IDLE is ignored. It is not queued.
- rx_rdy seen in any state other than WAIT_RESP is stale or unsolicited: clear it with clr_rx_rdy and do not update `resp`/`ack`. The exception is the cycle of entering WAIT_RESP, where it is kept.
- Simultaneous `snd_cmd` and a stale rx_rdy in IDLE: the command is accepted and rx_rdy is cleared.
- Reset mid-frame: FSM returns to IDLE immediately and TX returns to 1. The partial frame is abandoned and the far end must tolerate it.

## Timing
- Reset values: `busy`=0, `cmd_snt`=0, `resp_rdy`=0, `resp`=8'h00, `ack`=0, `timeout`=0, TX=1, FSM=IDLE, trmt=0, clr_rx_rdy=0.
- `busy` goes high the cycle after `snd_cmd` is accepted.
- trmt for the high byte is asserted 1 cycle after acceptance. The high byte start bit appears on TX 2 cycles after acceptance (UART register stage).
- Low-byte trmt is asserted 1 cycle after the high-byte tx_done is sampled. No idle bit time is added beyond the UART stop bit.
- Frame length is set by the UART: 10 bit-times per byte.
- `resp_rdy`, `resp`, `ack` and the `busy` drop all occur 1 cycle after rx_rdy is sampled in WAIT_RESP.
- The earliest next `snd_cmd` is accepted on the cycle `busy` is 0.

## Configuration
- `REMOTE_COMM_TIMEOUT_EN` defined: a 24-bit counter clears on WAIT_RESP entry and increments each cycle in WAIT_RESP. When it reaches TIMEOUT_CYCLES-1 without rx_rdy: pulse `timeout`, force `ack`=0, leave `resp` unchanged, go to IDLE. If rx_rdy and the terminal count coincide, the response wins and there is no timeout.
- Not defined: no counter; WAIT_RESP waits indefinitely; `timeout` is tied 0.

## Test plan
- Loopback far-end model replies 8'hA5. `snd_cmd` with cmd=16'h2C35 -> TX carries bytes 8'h2C then 8'h35 (LSB first, start 0, stop 1); `cmd_snt` pulses once; `resp_rdy` pulses; `resp`=8'hA5, `ack`=1, `busy`=0.
- Far end replies 8'h5A -> `resp`=8'h5A, `ack`=0.
- `snd_cmd` with cmd=16'h1111 pulsed again during WAIT_HI and WAIT_RESP -> ignored; exactly 2 bytes sent and 1 `resp_rdy`.
- Unsolicited byte 8'h77 injected while in IDLE, then a normal command that gets 8'hA5 -> `resp` never shows 8'h77; final `resp`=8'hA5.
- `rst` asserted halfway through the low byte -> TX=1, `busy`=0 within the same cycle. A new command afterwards completes normally.
- With `REMOTE_COMM_TIMEOUT_EN` and TIMEOUT_CYCLES=1000, no reply -> `timeout` pulses exactly 1000 cycles after WAIT_RESP entry; `ack`=0; `busy`=0.

Source files
------------

// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - host command initiator: 16-bit command out over UART, one-byte ack back
// Optional response timeout compiled in with REMOTE_COMM_TIMEOUT_EN.
module remote_comm #(
    parameter logic [7:0]  RESP_ACK       = 8'hA5,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
    parameter logic [15:0] BAUD_DIV       = 16'd2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    input  logic        RX,
    output logic        TX,
    output logic        busy,
    output logic        cmd_snt,
    output logic        resp_rdy,
    output logic [7:0]  resp,
    output logic        ack,
    output logic        timeout
);
    typedef enum logic [2:0] {IDLE, SND_HI, WAIT_HI, SND_LO, WAIT_LO, WAIT_RESP} state_t;

    state_t      state_q;
    logic [15:0] shadow_q;
    logic [7:0]  tx_data_q;
    logic        trmt_q, clr_q, cmd_snt_q, resp_rdy_q, ack_q;
    logic [7:0]  resp_q;
    logic        tx_done, rx_rdy;
    logic [7:0]  rx_data;
    logic        rx_fresh;

    remote_comm_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk       (clk),
        .rst_n     (~rst),
        .RX        (RX),
        .TX        (TX),
        .trmt      (trmt_q),
        .tx_data   (tx_data_q),
        .tx_done   (tx_done),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .clr_rx_rdy(clr_q)
    );

    // A byte already being cleared must not be seen a second time.
    assign rx_fresh = rx_rdy & ~clr_q;

`ifdef REMOTE_COMM_TIMEOUT_EN
    logic [23:0] tmo_cnt_q;
    logic        timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shadow_q   <= 16'h0000;
            tx_data_q  <= 8'h00;
            trmt_q     <= 1'b0;
            clr_q      <= 1'b0;
            cmd_snt_q  <= 1'b0;
            resp_rdy_q <= 1'b0;
            resp_q     <= 8'h00;
            ack_q      <= 1'b0;
`ifdef REMOTE_COMM_TIMEOUT_EN
            tmo_cnt_q  <= 24'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            trmt_q     <= 1'b0;
            clr_q      <= 1'b0;
            cmd_snt_q  <= 1'b0;
            resp_rdy_q <= 1'b0;
`ifdef REMOTE_COMM_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: if (snd_cmd) begin
                    shadow_q  <= cmd;
                    tx_data_q <= cmd[15:8];
                    trmt_q    <= 1'b1;
                    state_q   <= SND_HI;
                end
                SND_HI: begin
                    tx_data_q <= shadow_q[15:8];
                    state_q   <= WAIT_HI;
                end
                WAIT_HI: if (tx_done) begin
                    tx_data_q <= shadow_q[7:0];
                    trmt_q    <= 1'b1;
                    state_q   <= SND_LO;
                end
                SND_LO: state_q <= WAIT_LO;
                WAIT_LO: if (tx_done) begin
                    cmd_snt_q <= 1'b1;
                    state_q   <= WAIT_RESP;
`ifdef REMOTE_COMM_TIMEOUT_EN
                    tmo_cnt_q <= 24'd0;
`endif
                end
                WAIT_RESP: begin
                    if (rx_fresh) begin
                        resp_q     <= rx_data;
                        ack_q      <= (rx_data == RESP_ACK);
                        resp_rdy_q <= 1'b1;
                        clr_q      <= 1'b1;
                        state_q    <= IDLE;
                    end
`ifdef REMOTE_COMM_TIMEOUT_EN
                    else if (tmo_cnt_q == TIMEOUT_CYCLES - 24'd1) begin
                        timeout_q <= 1'b1;
                        ack_q     <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 24'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
            // Bytes outside WAIT_RESP are stale, except one landing as WAIT_RESP is entered.
            if (rx_fresh && state_q != WAIT_RESP && !(state_q == WAIT_LO && tx_done))
                clr_q <= 1'b1;
        end
    end

    assign busy     = (state_q != IDLE);
    assign cmd_snt  = cmd_snt_q;
    assign resp_rdy = resp_rdy_q;
    assign resp     = resp_q;
    assign ack      = ack_q;
endmodule

// 8N1 UART; TX and rx_rdy are registered, tx_done is a one-cycle pulse after the stop bit.
module remote_comm_uart #(
    parameter logic [15:0] BAUD_DIV = 16'd2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    input  logic       clr_rx_rdy
);
    logic        tx_busy_q, tx_q, tx_done_q;
    logic [8:0]  tx_shift_q;
    logic [15:0] tx_baud_q;
    logic [3:0]  tx_bit_q;
    logic        rx_s1_q, rx_s2_q, rx_busy_q, rx_rdy_q;
    logic [7:0]  rx_shift_q, rx_data_q;
    logic [15:0] rx_baud_q;
    logic [3:0]  rx_bit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_q  <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
            tx_shift_q <= 9'h1FF;
            tx_baud_q  <= 16'd0;
            tx_bit_q   <= 4'd0;
        end else begin
            tx_done_q <= 1'b0;
            if (!tx_busy_q) begin
                if (trmt) begin
                    tx_busy_q  <= 1'b1;
                    tx_q       <= 1'b0;
                    tx_shift_q <= {1'b1, tx_data};
                    tx_baud_q  <= 16'd0;
                    tx_bit_q   <= 4'd0;
                end
            end else if (tx_baud_q == BAUD_DIV - 16'd1) begin
                tx_baud_q <= 16'd0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b1;
                    tx_q      <= 1'b1;
                end else begin
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                    tx_bit_q   <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_baud_q <= tx_baud_q + 16'd1;
            end
        end
    end

    // Receiver samples mid-bit: first wrap is half a bit after the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_rdy_q   <= 1'b0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_baud_q  <= 16'd0;
            rx_bit_q   <= 4'd0;
        end else begin
            rx_s1_q <= RX;
            rx_s2_q <= rx_s1_q;
            if (clr_rx_rdy) rx_rdy_q <= 1'b0;
            if (!rx_busy_q) begin
                if (!rx_s2_q) begin
                    rx_busy_q <= 1'b1;
                    rx_baud_q <= BAUD_DIV >> 1;
                    rx_bit_q  <= 4'd0;
                end
            end else if (rx_baud_q == BAUD_DIV - 16'd1) begin
                rx_baud_q <= 16'd0;
                if (rx_bit_q == 4'd0) begin
                    if (rx_s2_q) rx_busy_q <= 1'b0;
                    else         rx_bit_q  <= 4'd1;
                end else if (rx_bit_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    if (rx_s2_q) begin
                        rx_rdy_q  <= 1'b1;
                        rx_data_q <= rx_shift_q;
                    end
                end else begin
                    rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 4'd1;
                end
            end else begin
                rx_baud_q <= rx_baud_q + 16'd1;
            end
        end
    end

    assign TX      = tx_q;
    assign tx_done = tx_done_q;
    assign rx_rdy  = rx_rdy_q;
    assign rx_data = rx_data_q;
endmodule

// File: tb/tb_remote_comm.sv
// tb/tb_remote_comm.sv - self-checking bench for remote_comm with serial far-end model
module tb_remote_comm;
    localparam int          BAUD = 8;
    localparam logic [7:0]  ACKB = 8'hA5;
    localparam logic [23:0] TMO  = 24'd1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snd_cmd = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        RX = 1'b1;
    logic        TX, busy, cmd_snt, resp_rdy, ack, timeout;
    logic [7:0]  resp;

    remote_comm #(.RESP_ACK(ACKB), .TIMEOUT_CYCLES(TMO), .BAUD_DIV(16'(BAUD))) dut (
        .clk(clk), .rst(rst), .snd_cmd(snd_cmd), .cmd(cmd), .RX(RX), .TX(TX),
        .busy(busy), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp),
        .ack(ack), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_snt = 0;
    int n_rdy = 0;
    bit saw77 = 1'b0;
    logic [7:0] txq[$];
    logic [7:0] mon_b;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (cmd_snt === 1'b1) n_snt++;
        if (resp_rdy === 1'b1) n_rdy++;
        if (resp === 8'h77) saw77 = 1'b1;
    end

    // Far-end byte decoder on TX: mid-bit sampling, LSB first.
    always begin
        @(negedge clk);
        if (TX === 1'b0 && rst === 1'b0) begin
            repeat (BAUD / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD) @(negedge clk);
                mon_b[i] = TX;
            end
            repeat (BAUD) @(negedge clk);
            txq.push_back(mon_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = 1'b1;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic pulse_snd(input logic [15:0] c);
        snd_cmd = 1'b1;
        cmd = c;
        @(negedge clk);
        snd_cmd = 1'b0;
        cmd = 16'($urandom);
    endtask

    // Full transaction; the model expects the two bytes of c and a reply-derived resp/ack.
    task automatic run_cmd(input logic [15:0] c, input logic [7:0] r, input bit extra);
        int base_snt, base_rdy, k;
        base_snt = n_snt;
        base_rdy = n_rdy;
        txq.delete();
        @(negedge clk);
        chk("busy_before_accept", busy, 0);
        pulse_snd(c);
        chk("busy_after_accept", busy, 1);
        chk("tx_idle_trmt_cycle", TX, 1);
        @(negedge clk);
        chk("tx_start_latency", TX, 0);
        if (extra) begin
            repeat (2) @(negedge clk);
            pulse_snd(16'h1111);
        end
        k = 0;
        while (n_snt == base_snt && k < 40 * BAUD) begin @(negedge clk); k++; end
        chk("cmd_snt_seen", n_snt - base_snt, 1);
        chk("tx_byte_count", txq.size(), 2);
        if (txq.size() >= 2) begin
            chk("tx_hi_byte", txq[0], c[15:8]);
            chk("tx_lo_byte", txq[1], c[7:0]);
        end
        if (extra) pulse_snd(16'h1111);
        send_rx(r);
        k = 0;
        while (n_rdy == base_rdy && k < 20 * BAUD) begin @(negedge clk); k++; end
        chk("resp_rdy_count", n_rdy - base_rdy, 1);
        chk("resp_value", resp, r);
        chk("ack_value", ack, (r == ACKB));
        chk("busy_after_resp", busy, 0);
        chk("timeout_quiet", timeout, 0);
        repeat (30 * BAUD) @(negedge clk);
        chk("tx_no_extra_bytes", txq.size(), 2);
        chk("cmd_snt_once", n_snt - base_snt, 1);
        chk("resp_rdy_once", n_rdy - base_rdy, 1);
    endtask

    initial begin
        int k, t0, t1, base_rdy;
        logic [15:0] rc;
        logic [7:0] rr;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_snt", cmd_snt, 0);
        chk("rst_resp_rdy", resp_rdy, 0);
        chk("rst_resp", resp, 8'h00);
        chk("rst_ack", ack, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_tx", TX, 1);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        run_cmd(16'h2C35, 8'hA5, 1'b0);
        run_cmd(16'h2C35, 8'h5A, 1'b0);
        run_cmd(16'($urandom), 8'hA5, 1'b1);

        base_rdy = n_rdy;
        send_rx(8'h77);
        repeat (4 * BAUD) @(negedge clk);
        chk("unsolicited_no_rdy", n_rdy - base_rdy, 0);
        chk("unsolicited_resp_held", resp, 8'hA5);
        chk("unsolicited_busy", busy, 0);
        run_cmd(16'($urandom), 8'hA5, 1'b0);
        chk("never_saw_77", saw77, 0);

        for (int i = 0; i < 6; i++) begin
            rc = 16'($urandom);
            rr = ($urandom_range(0, 1) == 0) ? ACKB : 8'($urandom);
            run_cmd(rc, rr, 1'b0);
        end

        // Reset halfway through the low byte.
        txq.delete();
        @(negedge clk);
        pulse_snd(16'hBEEF);
        k = 0;
        while (txq.size() < 1 && k < 30 * BAUD) begin @(negedge clk); k++; end
        chk("reset_hi_byte_seen", txq.size(), 1);
        repeat (6 * BAUD) @(negedge clk);
        chk("reset_busy_before", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("reset_tx_high", TX, 1);
        chk("reset_busy_low", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (14 * BAUD) @(negedge clk);
        chk("reset_resp_cleared", resp, 8'h00);
        run_cmd(16'h2C35, 8'hA5, 1'b0);

`ifdef REMOTE_COMM_TIMEOUT_EN
        txq.delete();
        @(negedge clk);
        pulse_snd(16'h0F0F);
        k = 0;
        while (cmd_snt !== 1'b1 && k < 40 * BAUD) begin @(negedge clk); k++; end
        chk("tmo_cmd_snt_seen", cmd_snt, 1);
        t0 = cyc;
        k = 0;
        while (timeout !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
        t1 = cyc;
        chk("tmo_seen", timeout, 1);
        chk("tmo_latency", t1 - t0, 1000);
        chk("tmo_ack", ack, 0);
        chk("tmo_busy", busy, 0);
        chk("tmo_resp_held", resp, 8'hA5);
        @(negedge clk);
        chk("tmo_one_cycle", timeout, 0);
`else
        t0 = 0;
        t1 = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
